// File: rtl/pe_conv3_row_if.sv
// Row-in / result-out stream bundle for pe_conv3_row.
// Ports: parallel_data, row_vld, i_sof, row_rdy (row side);
//        o_data, o_idx, o_vld, o_last, o_rdy (result side).
interface pe_conv3_row_if #(
   parameter int NPIX  = 32,
   parameter int ACC_W = 21
);
   localparam int RW = 8 * (NPIX + 2);
   localparam int IW = $clog2(NPIX);

   logic [RW-1:0]           parallel_data;
   logic                    row_vld;
   logic                    i_sof;
   logic                    row_rdy;
   logic signed [ACC_W-1:0] o_data;
   logic [IW-1:0]           o_idx;
   logic                    o_vld;
   logic                    o_last;
   logic                    o_rdy;

   modport master (
      output parallel_data, row_vld, i_sof, o_rdy,
      input  row_rdy, o_data, o_idx, o_vld, o_last
   );

   modport slave (
      input  parallel_data, row_vld, i_sof, o_rdy,
      output row_rdy, o_data, o_idx, o_vld, o_last
   );
endinterface

// File: rtl/pe_conv3_row.sv
// 3x3 row convolution PE: buffers 3 rows, computes NPIX sums,
// then streams them out one per o_rdy.
// Ports: PEclk, rst_n (sync, active-low), en (global freeze),
//        w_wr/w_addr/w_data (weight write), bus (row/result stream).
module pe_conv3_row #(
   parameter int NPIX  = 32,
   parameter int ACC_W = 21
) (
   input  logic              PEclk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              w_wr,
   input  logic [3:0]        w_addr,
   input  logic signed [7:0] w_data,
   pe_conv3_row_if.slave     bus
);
   localparam int RW = 8 * (NPIX + 2);
   localparam int IW = $clog2(NPIX);

   typedef enum logic [1:0] {IDLE, CALC, DRAIN} state_t;

   state_t                  state;
   logic [1:0]              cnt;
   logic [1:0]              cnt_nx;
   logic [RW-1:0]           lb [3];
   logic signed [7:0]       w [9];
   logic signed [ACC_W-1:0] rbuf [NPIX];
   logic signed [ACC_W-1:0] sum [NPIX];
   logic [IW-1:0]           idx;
   logic [IW-1:0]           idx_nx;
   logic                    vld;
   logic                    last;
   logic                    acc;

   function automatic logic signed [16:0] mul(
      input logic signed [7:0] a,
      input logic [7:0]        p
   );
      logic signed [8:0] px;
      px = $signed({1'b0, p});
      return a * px;
   endfunction

   assign bus.row_rdy = en && (state == IDLE);
   assign bus.o_data  = rbuf[idx];
   assign bus.o_idx   = idx;
   assign bus.o_vld   = vld;
   assign bus.o_last  = last;

   assign acc    = bus.row_vld && bus.row_rdy;
   assign idx_nx = idx + 1'b1;

   // i_sof restarts the frame so older rows never reach a sum.
   always_comb begin
      cnt_nx = cnt;
      if (bus.i_sof)
         cnt_nx = 2'd1;
      else if (cnt != 2'd3)
         cnt_nx = cnt + 2'd1;
   end

   // lb[0] is the oldest row, lb[2] the newest.
   always_comb begin
      for (int j = 0; j < NPIX; j++) begin
         sum[j] = '0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               sum[j] = sum[j] + ACC_W'(
                  mul(w[3*r+c], lb[r][8*(j+c) +: 8]));
            end
         end
      end
   end

   always_ff @(posedge PEclk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         vld   <= 1'b0;
         last  <= 1'b0;
         for (int r = 0; r < 3; r++) lb[r] <= '0;
         for (int k = 0; k < 9; k++) w[k] <= '0;
         for (int j = 0; j < NPIX; j++) rbuf[j] <= '0;
      end else if (en) begin
         if (w_wr && w_addr <= 4'd8 && state != DRAIN)
            w[w_addr] <= w_data;
         unique case (state)
            IDLE: begin
               if (acc) begin
                  lb[0] <= lb[1];
                  lb[1] <= lb[2];
                  lb[2] <= bus.parallel_data;
                  cnt   <= cnt_nx;
                  if (cnt_nx == 2'd3) state <= CALC;
               end
            end
            CALC: begin
               for (int j = 0; j < NPIX; j++) rbuf[j] <= sum[j];
               idx   <= '0;
               vld   <= 1'b1;
               last  <= (NPIX == 1);
               state <= DRAIN;
            end
            DRAIN: begin
               if (bus.o_rdy) begin
                  if (idx == IW'(NPIX - 1)) begin
                     vld   <= 1'b0;
                     last  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     idx  <= idx_nx;
                     last <= (idx_nx == IW'(NPIX - 1));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pe_conv3_row.sv
// Scoreboard bench for pe_conv3_row.
// Directed rows with hand-computed sums; monitor pops per transfer.
module tb_pe_conv3_row;
   localparam int NPIX  = 32;
   localparam int ACC_W = 21;
   localparam int RW    = 8 * (NPIX + 2);

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       w_wr = 1'b0;
   logic [3:0] w_addr = '0;
   logic signed [7:0] w_data = '0;

   pe_conv3_row_if #(.NPIX(NPIX), .ACC_W(ACC_W)) bus ();

   pe_conv3_row #(.NPIX(NPIX), .ACC_W(ACC_W)) dut (
      .PEclk  (clk),
      .rst_n  (rst_n),
      .en     (en),
      .w_wr   (w_wr),
      .w_addr (w_addr),
      .w_data (w_data),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int data;
      int idx;
      bit last;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input bit ok, input string name,
                      input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d",
                  name, act, req);
      end
   endtask

   task automatic push_ramp(input int base, input int slope);
      exp_t e;
      for (int j = 0; j < NPIX; j++) begin
         e.data = base + slope * j;
         e.idx  = j;
         e.last = (j == NPIX - 1);
         q.push_back(e);
      end
   endtask

   function automatic logic [RW-1:0] mk_ramp();
      logic [RW-1:0] r;
      for (int k = 0; k < NPIX + 2; k++) r[8*k +: 8] = 8'(k);
      return r;
   endfunction

   function automatic logic [RW-1:0] mk_const(input int v);
      logic [RW-1:0] r;
      for (int k = 0; k < NPIX + 2; k++) r[8*k +: 8] = 8'(v);
      return r;
   endfunction

   task automatic wr_w(input int a, input int d);
      w_wr   = 1'b1;
      w_addr = 4'(a);
      w_data = 8'(d);
      @(posedge clk); #1;
      w_wr = 1'b0;
   endtask

   task automatic wr_all(input int d);
      for (int a = 0; a < 9; a++) wr_w(a, d);
   endtask

   task automatic send_row(input logic [RW-1:0] r, input bit sof);
      bit ok = 1'b0;
      bus.parallel_data = r;
      bus.i_sof = sof;
      bus.row_vld = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (bus.row_rdy) begin
            ok = 1'b1;
            break;
         end
      end
      chk(ok, "row_accept_timeout", 0, 1);
      @(posedge clk); #1;
      bus.row_vld = 1'b0;
      bus.i_sof = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (q.size() == 0 && bus.row_rdy) begin
            ok = 1'b1;
            break;
         end
      end
      chk(ok, "drain_timeout", q.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic wait_idx(input int v);
      bit ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (bus.o_vld && int'(bus.o_idx) == v) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk(ok, "wait_idx", int'(bus.o_idx), v);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && en && bus.o_vld && bus.o_rdy) begin
            if (q.size() == 0) begin
               chk(1'b0, "unexpected_out", int'(bus.o_idx), -1);
            end else begin
               e = q.pop_front();
               chk(int'(bus.o_data) == e.data, "o_data",
                   int'(bus.o_data), e.data);
               chk(int'(bus.o_idx) == e.idx, "o_idx",
                   int'(bus.o_idx), e.idx);
               chk(bus.o_last == e.last, "o_last",
                   int'(bus.o_last), int'(e.last));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic signed [ACC_W-1:0] hd;
      bus.parallel_data = '0;
      bus.row_vld = 1'b0;
      bus.i_sof = 1'b0;
      bus.o_rdy = 1'b1;
      rst_n = 1'b0;
      en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk(bus.o_vld == 1'b0, "rst_vld", int'(bus.o_vld), 0);
      chk(bus.o_idx == '0, "rst_idx", int'(bus.o_idx), 0);
      chk(bus.o_data == '0, "rst_data", int'(bus.o_data), 0);
      chk(bus.o_last == 1'b0, "rst_last", int'(bus.o_last), 0);
      chk(bus.row_rdy == 1'b1, "rst_rdy", int'(bus.row_rdy), 1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // identity kernel on a ramp, plus latency
      wr_w(4, 1);
      send_row(mk_ramp(), 1'b1);
      send_row(mk_ramp(), 1'b0);
      push_ramp(1, 1);
      send_row(mk_ramp(), 1'b0);
      @(negedge clk);
      chk(bus.o_vld == 1'b0, "lat_t1", int'(bus.o_vld), 0);
      @(posedge clk); #1;
      chk(bus.o_vld == 1'b1, "lat_t2", int'(bus.o_vld), 1);
      wait_drain();

      // all ones, full white, then a black row
      wr_all(1);
      send_row(mk_const(255), 1'b1);
      send_row(mk_const(255), 1'b0);
      push_ramp(2295, 0);
      send_row(mk_const(255), 1'b0);
      wait_drain();
      push_ramp(1530, 0);
      send_row(mk_const(0), 1'b0);
      wait_idx(5);
      bus.o_rdy = 1'b0;
      hd = bus.o_data;
      repeat (10) begin
         @(posedge clk); #1;
         chk(bus.o_data == hd && bus.o_idx == 5 &&
             bus.o_vld && !bus.row_rdy, "stall_hold",
             int'(bus.o_idx), 5);
      end
      bus.o_rdy = 1'b1;
      wait_drain();

      // most negative weights, freeze and ignored writes
      wr_all(-128);
      send_row(mk_const(255), 1'b1);
      send_row(mk_const(255), 1'b0);
      push_ramp(-293760, 0);
      send_row(mk_const(255), 1'b0);
      wait_idx(3);
      en = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         chk(bus.o_idx == 3 && bus.o_vld && !bus.row_rdy,
             "en_freeze", int'(bus.o_idx), 3);
      end
      en = 1'b1;
      wr_w(0, 5);
      wait_drain();
      en = 1'b0;
      wr_w(1, 7);
      chk(bus.row_rdy == 1'b0, "en0_rdy", int'(bus.row_rdy), 0);
      en = 1'b1;
      push_ramp(-293760, 0);
      send_row(mk_const(255), 1'b0);
      wait_drain();

      // frame restart discards older rows
      wr_all(1);
      send_row(mk_const(7), 1'b1);
      send_row(mk_const(9), 1'b0);
      send_row(mk_ramp(), 1'b1);
      send_row(mk_const(2), 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk(bus.o_vld == 1'b0, "sof_no_out", int'(bus.o_vld), 0);
      push_ramp(18, 3);
      send_row(mk_const(3), 1'b0);
      wait_drain();

      // reset mid-drain
      for (int a = 0; a < 9; a++) wr_w(a, (a == 4) ? 1 : 0);
      send_row(mk_ramp(), 1'b1);
      send_row(mk_ramp(), 1'b0);
      push_ramp(1, 1);
      send_row(mk_ramp(), 1'b0);
      wait_idx(10);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk(bus.o_vld == 1'b0, "mid_rst_vld", int'(bus.o_vld), 0);
      chk(bus.row_rdy == 1'b1, "mid_rst_rdy", int'(bus.row_rdy), 1);
      chk(bus.o_idx == '0, "mid_rst_idx", int'(bus.o_idx), 0);
      chk(bus.o_last == 1'b0, "mid_rst_last", int'(bus.o_last), 0);
      q.delete();
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_row(mk_ramp(), 1'b0);
      send_row(mk_ramp(), 1'b0);
      push_ramp(0, 0);
      send_row(mk_ramp(), 1'b0);
      wait_drain();

      chk(q.size() == 0, "queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
